// File: rtl/spi_slave_param.sv
`timescale 1ns/1ps
// SPI slave with a runtime-independent mode (CPOL/CPHA), bit order and frame width.
// SCLK/CS/MOSI are resampled into the clk domain; all data paths run on clk.
module spi_slave_param #(
    parameter int WIDTH     = 32'sd8,
    parameter int CPOL      = 32'sd0,
    parameter int CPHA      = 32'sd0,
    parameter int LSB_FIRST = 32'sd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCLK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST      = CW'(WIDTH - 32'sd1);
    localparam logic [CW-1:0]   ONE       = CW'(1'b1);
    localparam logic [CW-1:0]   ZERO      = CW'(1'b0);
    localparam logic            IDLE_SCLK = (CPOL != 32'sd0);
    localparam logic            PHASE1    = (CPHA != 32'sd0);
    localparam logic            LSB       = (LSB_FIRST != 32'sd0);

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (LSB) first_bit = w[0];
        else     first_bit = w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (LSB) shift_word = {1'b0, w[WIDTH-1:1]};
        else     shift_word = {w[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] rx_next(input logic [WIDTH-1:0] w, input logic b);
        if (LSB) rx_next = {b, w[WIDTH-1:1]};
        else     rx_next = {w[WIDTH-2:0], b};
    endfunction

    logic [2:0]       sclk_pipe_q, sclk_pipe_d;
    logic [2:0]       cs_pipe_q, cs_pipe_d;
    logic [1:0]       mosi_pipe_q, mosi_pipe_d;
    logic [1:0]       live_q, live_d;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             miso_q, miso_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             tx_underrun_q, tx_underrun_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;

    logic             sclk_rise_s, sclk_fall_s, lead_s, trail_s, sample_s, shift_s;
    logic             cs_fall_s, cs_rise_s, load_s;
    logic [WIDTH-1:0] tx_word_s, tx_shifted_s, rx_next_s;

    // CS edges are only trusted once the whole CS pipe holds real pin samples,
    // so a CS already low when reset releases does not start a frame.
    assign sclk_rise_s  = sclk_pipe_q[1] & ~sclk_pipe_q[2];
    assign sclk_fall_s  = ~sclk_pipe_q[1] & sclk_pipe_q[2];
    assign lead_s       = IDLE_SCLK ? sclk_fall_s : sclk_rise_s;
    assign trail_s      = IDLE_SCLK ? sclk_rise_s : sclk_fall_s;
    assign sample_s     = PHASE1 ? trail_s : lead_s;
    assign shift_s      = PHASE1 ? lead_s : trail_s;
    assign cs_fall_s    = (live_q == 2'd3) & ~cs_pipe_q[1] & cs_pipe_q[2];
    assign cs_rise_s    = cs_pipe_q[1] & ~cs_pipe_q[2];
    assign tx_word_s    = hold_full_q ? hold_q : {WIDTH{1'b0}};
    assign tx_shifted_s = shift_word(tx_sh_q);
    assign rx_next_s    = rx_next(rx_sh_q, mosi_pipe_q[1]);

    // Next-state logic for the synchronisers, frame FSM and both data paths.
    always_comb begin
        sclk_pipe_d   = {sclk_pipe_q[1:0], SCLK};
        cs_pipe_d     = {cs_pipe_q[1:0], CS};
        mosi_pipe_d   = {mosi_pipe_q[0], MOSI};
        live_d        = (live_q == 2'd3) ? live_q : live_q + 2'd1;
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        load_s        = 1'b0;

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        else                        rx_valid_d = rx_valid_q;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall_s) begin
                    state_d = ST_SHIFT;
                    cnt_d   = ZERO;
                    rx_sh_d = {WIDTH{1'b0}};
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                    tx_sh_d = {WIDTH{1'b0}};
                    rx_sh_d = {WIDTH{1'b0}};
                    miso_d  = 1'b0;
                end else if (sample_s) begin
                    rx_sh_d = rx_next_s;
                    if (cnt_q == LAST) begin
                        cnt_d        = ZERO;
                        rx_data_d    = rx_next_s;
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_valid_q & ~rx_ready;
                        load_s       = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else if (shift_s) begin
                    // The first shift edge of a frame only presents bit 0 (CPHA=1)
                    // or is the tail of the previous frame and is skipped (CPHA=0).
                    if (PHASE1 && (cnt_q == ZERO)) begin
                        miso_d = first_bit(tx_sh_q);
                    end else if (cnt_q != ZERO) begin
                        tx_sh_d = tx_shifted_s;
                        miso_d  = first_bit(tx_shifted_s);
                    end else begin
                        miso_d = miso_q;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            tx_sh_d       = tx_word_s;
            tx_underrun_d = ~hold_full_q;
            hold_full_d   = 1'b0;
            if (PHASE1) miso_d = miso_q & (state_q == ST_SHIFT);
            else        miso_d = first_bit(tx_word_s);
        end else begin
            tx_underrun_d = 1'b0;
        end

        // Accept after the load so a word offered during a load is kept.
        if (tx_valid && tx_ready_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end

        tx_ready_d = ~hold_full_d;
        busy_d     = (state_d == ST_SHIFT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_pipe_q   <= {3{IDLE_SCLK}};
            cs_pipe_q     <= 3'b111;
            mosi_pipe_q   <= 2'b00;
            live_q        <= 2'd0;
            state_q       <= ST_IDLE;
            cnt_q         <= ZERO;
            tx_sh_q       <= {WIDTH{1'b0}};
            rx_sh_q       <= {WIDTH{1'b0}};
            hold_q        <= {WIDTH{1'b0}};
            hold_full_q   <= 1'b0;
            miso_q        <= 1'b0;
            rx_data_q     <= {WIDTH{1'b0}};
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            tx_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            sclk_pipe_q   <= sclk_pipe_d;
            cs_pipe_q     <= cs_pipe_d;
            mosi_pipe_q   <= mosi_pipe_d;
            live_q        <= live_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_sh_q       <= tx_sh_d;
            rx_sh_q       <= rx_sh_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            tx_ready_q    <= tx_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign MISO        = miso_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_param.sv
`timescale 1ns/1ps
// Directed bench: instance A uses default parameters (mode 0, LSB first, 8 bits),
// instance B uses mode 3, MSB first, 16 bits. SCLK runs at clk/8.
module tb_spi_slave_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk_a, cs_a, mosi_a, miso_a;
    logic [7:0]  tx_data_a, rx_data_a;
    logic        tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
    logic        rx_overrun_a, tx_underrun_a, busy_a;
    logic        sclk_b, cs_b, mosi_b, miso_b;
    logic [15:0] tx_data_b, rx_data_b;
    logic        tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
    logic        rx_overrun_b, tx_underrun_b, busy_b;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_unf_a = 0;
    int n_ovr_a = 0;
    int n_unf_b = 0;
    int n_ovr_b = 0;

    spi_slave_param dut_a (
        .clk(clk), .reset(reset), .SCLK(sclk_a), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_overrun(rx_overrun_a), .tx_underrun(tx_underrun_a), .busy(busy_a)
    );

    spi_slave_param #(.WIDTH(16), .CPOL(1), .CPHA(1), .LSB_FIRST(0)) dut_b (
        .clk(clk), .reset(reset), .SCLK(sclk_b), .CS(cs_b), .MOSI(mosi_b), .MISO(miso_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_overrun(rx_overrun_b), .tx_underrun(tx_underrun_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Pulse counters for the single-cycle flags.
    always @(posedge clk) begin
        if (tx_underrun_a) n_unf_a <= n_unf_a + 1;
        if (rx_overrun_a)  n_ovr_a <= n_ovr_a + 1;
        if (tx_underrun_b) n_unf_b <= n_unf_b + 1;
        if (rx_overrun_b)  n_ovr_b <= n_ovr_b + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_a(input logic [7:0] v);
        tx_data_a = v; tx_valid_a = 1'b1;
        wait_clk(1);
        tx_valid_a = 1'b0;
    endtask

    task automatic ack_a();
        rx_ready_a = 1'b1;
        wait_clk(1);
        rx_ready_a = 1'b0;
    endtask

    // Mode 0, LSB first: drive MOSI, master samples MISO on the rising edge.
    task automatic xfer_a(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_a = mo[i];
            wait_clk(4);
            sclk_a = 1'b1;
            mi[i] = miso_a;
            wait_clk(4);
            sclk_a = 1'b0;
        end
    endtask

    // Mode 3, MSB first: shift on falling, master samples MISO on rising.
    task automatic xfer_b(input logic [15:0] mo, output logic [15:0] mi);
        mi = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            sclk_b = 1'b0;
            mosi_b = mo[15-i];
            wait_clk(4);
            sclk_b = 1'b1;
            mi[15-i] = miso_b;
            wait_clk(4);
        end
    endtask

    initial begin
        logic [7:0]  mi, mi2;
        logic [15:0] mib;
        int          snap;

        reset = 1'b0;
        sclk_a = 1'b0; cs_a = 1'b1; mosi_a = 1'b0; tx_data_a = 8'h00; tx_valid_a = 1'b0; rx_ready_a = 1'b0;
        sclk_b = 1'b1; cs_b = 1'b1; mosi_b = 1'b0; tx_data_b = 16'h0000; tx_valid_b = 1'b0; rx_ready_b = 1'b0;
        wait_clk(3);
        chk("rst_tx_ready",    32'(tx_ready_a),    32'h1);
        chk("rst_rx_valid",    32'(rx_valid_a),    32'h0);
        chk("rst_rx_data",     32'(rx_data_a),     32'h0);
        chk("rst_busy",        32'(busy_a),        32'h0);
        chk("rst_miso",        32'(miso_a),        32'h0);
        chk("rst_overrun",     32'(rx_overrun_a),  32'h0);
        chk("rst_underrun",    32'(tx_underrun_a), 32'h0);
        chk("rst_b_tx_ready",  32'(tx_ready_b),    32'h1);
        reset = 1'b1;
        wait_clk(4);

        // Basic mode-0 frame.
        load_a(8'h3A);
        chk("accept_tx_ready", 32'(tx_ready_a), 32'h0);
        cs_a = 1'b0; wait_clk(8);
        chk("frame_busy",      32'(busy_a),     32'h1);
        chk("load_tx_ready",   32'(tx_ready_a), 32'h1);
        xfer_a(8'hDA, 8, mi);
        cs_a = 1'b1; wait_clk(8);
        chk("basic_rx_data",   32'(rx_data_a),  32'hDA);
        chk("basic_rx_valid",  32'(rx_valid_a), 32'h1);
        chk("basic_miso_cap",  32'(mi),         32'h3A);
        chk("idle_miso",       32'(miso_a),     32'h0);
        chk("idle_busy",       32'(busy_a),     32'h0);
        ack_a();
        chk("ack_rx_valid",    32'(rx_valid_a), 32'h0);

        // Back-to-back frames with rx_ready low.
        snap = n_ovr_a;
        load_a(8'h11);
        cs_a = 1'b0; wait_clk(8);
        load_a(8'h22);
        xfer_a(8'h5C, 8, mi);
        xfer_a(8'hC3, 8, mi2);
        cs_a = 1'b1; wait_clk(8);
        chk("b2b_cap1",        32'(mi),             32'h11);
        chk("b2b_cap2",        32'(mi2),            32'h22);
        chk("b2b_rx_data",     32'(rx_data_a),      32'hC3);
        chk("b2b_rx_valid",    32'(rx_valid_a),     32'h1);
        chk("b2b_overruns",    32'(n_ovr_a - snap), 32'h1);
        ack_a();

        // Frame started with empty holding register.
        snap = n_unf_a;
        cs_a = 1'b0; wait_clk(8);
        load_a(8'h77);
        xfer_a(8'h0F, 8, mi);
        cs_a = 1'b1; wait_clk(8);
        chk("unf_miso_cap",    32'(mi),             32'h00);
        chk("unf_pulses",      32'(n_unf_a - snap), 32'h1);
        chk("unf_rx_data",     32'(rx_data_a),      32'h0F);
        ack_a();

        // Abort after 5 bits; the word queued during the frame is kept.
        load_a(8'h99);
        cs_a = 1'b0; wait_clk(8);
        load_a(8'h6B);
        xfer_a(8'hFF, 5, mi);
        cs_a = 1'b1; wait_clk(8);
        chk("abort_busy",      32'(busy_a),     32'h0);
        chk("abort_rx_valid",  32'(rx_valid_a), 32'h0);
        chk("abort_rx_data",   32'(rx_data_a),  32'h0F);
        chk("abort_hold_kept", 32'(tx_ready_a), 32'h0);
        cs_a = 1'b0; wait_clk(8);
        xfer_a(8'h81, 8, mi);
        cs_a = 1'b1; wait_clk(8);
        chk("post_abort_rx",   32'(rx_data_a),  32'h81);
        chk("post_abort_vld",  32'(rx_valid_a), 32'h1);
        chk("post_abort_cap",  32'(mi),         32'h6B);
        ack_a();

        // Reset pulsed at bit 3.
        load_a(8'h44);
        cs_a = 1'b0; wait_clk(8);
        xfer_a(8'hFF, 3, mi);
        reset = 1'b0;
        wait_clk(2);
        chk("mid_rst_busy",     32'(busy_a),        32'h0);
        chk("mid_rst_tx_ready", 32'(tx_ready_a),    32'h1);
        chk("mid_rst_rx_data",  32'(rx_data_a),     32'h0);
        chk("mid_rst_rx_valid", 32'(rx_valid_a),    32'h0);
        chk("mid_rst_miso",     32'(miso_a),        32'h0);
        chk("mid_rst_underrun", 32'(tx_underrun_a), 32'h0);
        reset = 1'b1;
        wait_clk(8);
        chk("rst_cs_low_idle",  32'(busy_a),        32'h0);
        cs_a = 1'b1; wait_clk(8);
        load_a(8'h5A);
        cs_a = 1'b0; wait_clk(8);
        xfer_a(8'hA5, 8, mi);
        cs_a = 1'b1; wait_clk(8);
        chk("post_rst_rx_data", 32'(rx_data_a),  32'hA5);
        chk("post_rst_rx_vld",  32'(rx_valid_a), 32'h1);
        chk("post_rst_cap",     32'(mi),         32'h5A);

        // Mode 3, MSB first, 16-bit instance.
        tx_data_b = 16'hBEEF; tx_valid_b = 1'b1;
        wait_clk(1);
        tx_valid_b = 1'b0;
        cs_b = 1'b0; wait_clk(8);
        xfer_b(16'h1234, mib);
        cs_b = 1'b1; wait_clk(8);
        chk("m3_rx_data",   32'(rx_data_b),  32'h1234);
        chk("m3_rx_valid",  32'(rx_valid_b), 32'h1);
        chk("m3_miso_cap",  32'(mib),        32'hBEEF);
        chk("m3_busy",      32'(busy_b),     32'h0);
        chk("m3_underruns", 32'(n_unf_b),    32'h1);
        chk("m3_overruns",  32'(n_ovr_b),    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
